clock_set_ctrl: RTL and testbench

Control front-end for the HH:MM:SS clock datapath. It derives the 1 Hz tick from the 100 MHz system clock and debounces two push buttons (mode, up). A mode FSM (RUN/SET_HOUR/SET_MIN/SET_SEC) generates the single-cycle inc_hour/inc_min/inc_sec pulses that drive the clock counters. It also provides a blink enable so the display can flash the field being edited.

---
 rtl/clock_pkg.sv | 24 ++
 rtl/button_debounce.sv | 49 ++++
 rtl/clock_set_ctrl.sv | 155 +++++++++++++++
 tb/tb_clock_set_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared mode encodings, default timing constants and a counter-width helper
// for the clock-setting front-end.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_SEC  = 2'd3
  } mode_t;

  localparam int DEF_CLK_FREQ_HZ     = 100_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = 2_000_000;
  localparam int DEF_REPEAT_DELAY    = 50_000_000;
  localparam int DEF_REPEAT_PERIOD   = 20_000_000;
  localparam int DEF_BLINK_HALF      = 25_000_000;
  localparam int DEF_TIMEOUT_CYCLES  = 1_000_000_000;

  // Bits needed for a counter that runs 0..n-1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a stability counter; emits the accepted
// level and a one-cycle pulse on each accepted rising edge.
module button_debounce
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int W = cnt_width(DEBOUNCE_CYCLES);

  logic         sync1;
  logic         sync2;
  logic         level_d;
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      // Any sample that agrees with the accepted level restarts the count.
      if (sync2 != level) begin
        if (cnt == W'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Clock-setting front-end: 1 Hz prescaler, mode FSM, increment pulses with
// auto-repeat, blink generator and SET-state inactivity timeout.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = DEF_CLK_FREQ_HZ,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int BLINK_HALF      = DEF_BLINK_HALF,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic       tick_1Hz,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       inc_hour,
  output logic [1:0] mode,
  output logic       blink_on
);

  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int PS_W   = cnt_width(CLK_FREQ_HZ);
  localparam int TO_W   = cnt_width(TIMEOUT_CYCLES);
  localparam int RP_W   = cnt_width(RP_MAX);
  localparam int BL_W   = cnt_width(BLINK_HALF);

  logic            mode_press;
  logic            up_press;
  logic            up_level;
  logic            unused_mode_level;

  mode_t           state_q;
  mode_t           state_n;
  logic [PS_W-1:0] ps_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [RP_W-1:0] rep_cnt;
  logic [RP_W-1:0] rep_limit;
  logic [BL_W-1:0] bl_cnt;
  logic            rep_active;
  logic            rep_first;
  logic            up_fire;
  logic            rep_fire;
  logic            fire;
  logic            stay;
  logic            run_stay;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk   (clk_100MHz),
    .rst_n (reset_n),
    .btn   (btn_mode),
    .level (unused_mode_level),
    .press (mode_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_db (
    .clk   (clk_100MHz),
    .rst_n (reset_n),
    .btn   (btn_up),
    .level (up_level),
    .press (up_press)
  );

  assign mode = state_q;

  // A mode press in the same cycle swallows the up press.
  assign up_fire   = up_press & ~mode_press & (state_q != MODE_RUN);
  assign rep_limit = rep_first ? RP_W'(REPEAT_DELAY - 1) : RP_W'(REPEAT_PERIOD - 1);
  assign rep_fire  = rep_active & up_level & ~mode_press & (rep_cnt == rep_limit);
  assign fire      = up_fire | rep_fire;

  always_comb begin
    state_n = state_q;
    if (mode_press) begin
      case (state_q)
        MODE_RUN:      state_n = MODE_SET_HOUR;
        MODE_SET_HOUR: state_n = MODE_SET_MIN;
        MODE_SET_MIN:  state_n = MODE_SET_SEC;
        default:       state_n = MODE_RUN;
      endcase
    end else if ((state_q != MODE_RUN) && !up_press && !rep_fire &&
                 (to_cnt == TO_W'(TIMEOUT_CYCLES - 1))) begin
      state_n = MODE_RUN;
    end
  end

  assign stay     = (state_n == state_q);
  assign run_stay = (state_q == MODE_RUN) && stay;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= MODE_RUN;
      ps_cnt     <= '0;
      tick_1Hz   <= 1'b0;
      to_cnt     <= '0;
      rep_active <= 1'b0;
      rep_first  <= 1'b0;
      rep_cnt    <= '0;
      inc_hour   <= 1'b0;
      inc_min    <= 1'b0;
      inc_sec    <= 1'b0;
      blink_on   <= 1'b1;
      bl_cnt     <= '0;
    end else begin
      state_q <= state_n;

      // Prescaler only runs while RUN is held, so RUN entry restarts a full period.
      if (run_stay) begin
        tick_1Hz <= (ps_cnt == PS_W'(CLK_FREQ_HZ - 1));
        ps_cnt   <= (ps_cnt == PS_W'(CLK_FREQ_HZ - 1)) ? '0 : ps_cnt + PS_W'(1);
      end else begin
        tick_1Hz <= 1'b0;
        ps_cnt   <= '0;
      end

      if ((state_q == MODE_RUN) || !stay || up_press || mode_press || rep_fire) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end

      if (up_fire) begin
        rep_active <= 1'b1;
        rep_first  <= 1'b1;
        rep_cnt    <= '0;
      end else if (!rep_active || !up_level || !stay) begin
        rep_active <= 1'b0;
        rep_cnt    <= '0;
      end else if (rep_fire) begin
        rep_first <= 1'b0;
        rep_cnt   <= '0;
      end else begin
        rep_cnt <= rep_cnt + RP_W'(1);
      end

      inc_hour <= fire && (state_q == MODE_SET_HOUR);
      inc_min  <= fire && (state_q == MODE_SET_MIN);
      inc_sec  <= fire && (state_q == MODE_SET_SEC);

      if ((state_n == MODE_RUN) || !stay || fire) begin
        blink_on <= 1'b1;
        bl_cnt   <= '0;
      end else if (bl_cnt == BL_W'(BLINK_HALF - 1)) begin
        blink_on <= ~blink_on;
        bl_cnt   <= '0;
      end else begin
        bl_cnt <= bl_cnt + BL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with shortened timing parameters; every
// expected value below is hand-derived from the cycle behaviour of the block.
module tb_clock_set_ctrl;

  logic       clk_100MHz = 1'b0;
  logic       reset_n;
  logic       btn_mode;
  logic       btn_up;
  logic       tick_1Hz;
  logic       inc_sec;
  logic       inc_min;
  logic       inc_hour;
  logic [1:0] mode;
  logic       blink_on;

  int checks = 0;
  int errors = 0;

  clock_set_ctrl #(
    .CLK_FREQ_HZ     (10),
    .DEBOUNCE_CYCLES (3),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (4),
    .BLINK_HALF      (5),
    .TIMEOUT_CYCLES  (40)
  ) u_dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .btn_mode   (btn_mode),
    .btn_up     (btn_up),
    .tick_1Hz   (tick_1Hz),
    .inc_sec    (inc_sec),
    .inc_min    (inc_min),
    .inc_hour   (inc_hour),
    .mode       (mode),
    .blink_on   (blink_on)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then observed 1 ns after the edge.
  task automatic step();
    @(posedge clk_100MHz);
    #1;
  endtask

  // Raw press lands on the edge after it is driven; mode updates 7 steps later.
  task automatic mode_press(input logic [1:0] old_m, input logic [1:0] new_m, input string tag);
    btn_mode = 1'b1;
    repeat (6) step();
    check_eq({tag, "_before"}, 32'(mode), 32'(old_m));
    step();
    check_eq({tag, "_after"}, 32'(mode), 32'(new_m));
  endtask

  task automatic mode_release();
    btn_mode = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    reset_n  = 1'b0;
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    repeat (3) step();
    check_eq("rst_mode", 32'(mode), 32'd0);
    check_eq("rst_tick", 32'(tick_1Hz), 32'd0);
    check_eq("rst_inc", 32'({inc_hour, inc_min, inc_sec}), 32'd0);
    check_eq("rst_blink", 32'(blink_on), 32'd1);

    // Tick cadence in RUN
    reset_n = 1'b1;
    for (int i = 1; i <= 35; i++) begin
      step();
      check_eq($sformatf("tick_c%0d", i), 32'(tick_1Hz), 32'((i % 10) == 0));
      check_eq("run_mode", 32'(mode), 32'd0);
      check_eq("run_blink", 32'(blink_on), 32'd1);
    end

    // Mode cycle, blink in SET_HOUR, first tick after return to RUN
    mode_press(2'd0, 2'd1, "m1");
    btn_mode = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      step();
      check_eq($sformatf("blink_c%0d", j), 32'(blink_on), 32'(j < 5));
    end
    mode_press(2'd1, 2'd2, "m2");
    mode_release();
    mode_press(2'd2, 2'd3, "m3");
    mode_release();
    mode_press(2'd3, 2'd0, "m4");
    btn_mode = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      step();
      check_eq($sformatf("tick_ret_c%0d", j), 32'(tick_1Hz), 32'(j == 10));
    end

    // Increment and auto-repeat in SET_MIN
    mode_press(2'd0, 2'd1, "m5");
    mode_release();
    mode_press(2'd1, 2'd2, "m6");
    mode_release();
    btn_up = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      logic exp_p;
      if (k == 21) btn_up = 1'b0;
      step();
      exp_p = (k == 7) || (k == 15) || (k == 19) || (k == 23);
      check_eq($sformatf("inc_min_c%0d", k), 32'(inc_min), 32'(exp_p));
      check_eq("rep_inc_other", 32'({inc_hour, inc_sec}), 32'd0);
      if (exp_p) check_eq("rep_blink", 32'(blink_on), 32'd1);
    end
    check_eq("rep_mode", 32'(mode), 32'd2);

    // Bounce and simultaneous presses in SET_HOUR
    mode_press(2'd2, 2'd3, "m7");
    mode_release();
    mode_press(2'd3, 2'd0, "m8");
    mode_release();
    mode_press(2'd0, 2'd1, "m9");
    mode_release();
    for (int k = 1; k <= 12; k++) begin
      btn_up = (((k - 1) / 2) % 2) == 0;
      step();
      check_eq("bounce_inc", 32'({inc_hour, inc_min, inc_sec}), 32'd0);
    end
    btn_up = 1'b0;
    repeat (6) begin
      step();
      check_eq("bounce_tail", 32'({inc_hour, inc_min, inc_sec}), 32'd0);
    end
    btn_mode = 1'b1;
    btn_up   = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      check_eq($sformatf("conflict_inc_c%0d", k), 32'({inc_hour, inc_min, inc_sec}), 32'd0);
      if (k == 6) check_eq("conflict_before", 32'(mode), 32'd1);
      if (k == 7) check_eq("conflict_after", 32'(mode), 32'd2);
    end
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    repeat (8) step();

    // Timeout from SET_SEC, then up press ignored in RUN
    mode_press(2'd2, 2'd3, "m10");
    btn_mode = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      step();
      if (j == 39) check_eq("timeout_before", 32'(mode), 32'd3);
      if (j == 40) check_eq("timeout_after", 32'(mode), 32'd0);
    end
    btn_up = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check_eq("run_up_inc", 32'({inc_hour, inc_min, inc_sec}), 32'd0);
      check_eq("run_up_mode", 32'(mode), 32'd0);
    end
    btn_up = 1'b0;
    repeat (8) step();

    // Reset during auto-repeat
    mode_press(2'd0, 2'd1, "m11");
    mode_release();
    btn_up = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 7) check_eq("pre_rst_inc_hour", 32'(inc_hour), 32'd1);
    end
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_mode", 32'(mode), 32'd0);
    check_eq("mid_rst_tick", 32'(tick_1Hz), 32'd0);
    check_eq("mid_rst_inc", 32'({inc_hour, inc_min, inc_sec}), 32'd0);
    check_eq("mid_rst_blink", 32'(blink_on), 32'd1);
    step();
    step();
    reset_n = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      step();
      check_eq($sformatf("post_rst_press_c%0d", j), 32'(u_dut.u_up_db.press), 32'(j == 6));
      check_eq("post_rst_inc", 32'({inc_hour, inc_min, inc_sec}), 32'd0);
      check_eq("post_rst_mode", 32'(mode), 32'd0);
    end
    btn_up = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
